// File: rtl/count_scheduler.sv
// Two-requester burst scheduler driving the increment enable and counter select
// of a dual 64-bit counter datapath; round-robin grant, one burst at a time.
module count_scheduler #(
  parameter int LEN_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0_valid,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  input  logic             Hold,
  output logic             En,
  output logic             Slt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [LEN_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             cur_id;
  logic             last_winner;
  logic [LEN_W-1:0] rem_q;
  logic             gnt0, gnt1;
  logic             acc0, acc1;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_winner);
    gnt1 = req1_valid & (~req0_valid | ~last_winner);
  end

  always_comb begin
    req0_ready = (state == IDLE) & gnt0;
    req1_ready = (state == IDLE) & gnt1;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    En         = (state == RUN) & ~Hold;
    Slt        = (state == RUN) & cur_id;
    busy       = (state != IDLE);
    done       = (state == DONE);
    done_id    = (state == DONE) & cur_id;
    remaining  = rem_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      rem_q       <= '0;
      cur_id      <= 1'b0;
      last_winner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            cur_id      <= acc1;
            last_winner <= acc1;
            rem_q       <= acc1 ? req1_len : req0_len;
            state       <= ((acc1 ? req1_len : req0_len) == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!Hold) begin
            // Saturate so a corrupted zero count can never wrap.
            if (rem_q != '0) rem_q <= rem_q - LEN_W'(1);
            if (rem_q <= LEN_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Scoreboard bench: stimulus queues expected acceptances and per-busy-cycle
// output records; a negedge monitor pops and compares them.
module tb_count_scheduler;
  localparam int LEN_W = 16;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic             req0_ready, req1_ready;
  logic             Hold = 1'b0;
  logic             En, Slt, busy, done, done_id;
  logic [LEN_W-1:0] remaining;

  count_scheduler #(.LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
    .Hold(Hold), .En(En), .Slt(Slt), .busy(busy), .done(done),
    .done_id(done_id), .remaining(remaining)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic             en;
    logic             slt;
    logic             dn;
    logic             did;
    logic [LEN_W-1:0] rem;
  } rec_t;

  rec_t exp_q[$];
  logic acc_q[$];
  int   acc_t[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic mon_on = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_cmd(input logic id, input int len);
    acc_q.push_back(id);
    for (int i = len; i >= 1; i--) exp_q.push_back('{1'b1, id, 1'b0, 1'b0, LEN_W'(i)});
    exp_q.push_back('{1'b0, 1'b0, 1'b1, id, '0});
  endtask

  // Monitor: every acceptance and every busy cycle is an output event.
  always @(negedge Clk) begin
    if (mon_on) begin
      if (req0_valid && req0_ready) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 32'd0, 32'd1);
        else chk("acc_id", 32'd0, {31'd0, acc_q.pop_front()});
      end
      if (req1_valid && req1_ready) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 32'd1, 32'd2);
        else chk("acc_id", 32'd1, {31'd0, acc_q.pop_front()});
      end
      if (busy) begin
        chk("ready_in_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
        if (exp_q.size() == 0) chk("rec_unexpected", {12'd0, En, Slt, done, done_id, remaining}, 32'hFFFF_FFFF);
        else chk("rec", {12'd0, En, Slt, done, done_id, remaining}, {12'd0, exp_q.pop_front()});
      end else begin
        chk("idle_outs", {28'd0, En, Slt, done, done_id}, 32'd0);
      end
    end
  end

  // Drives n0/n1 commands on each port, holding valid until accepted and
  // re-raising it for the next command. Hold is raised for hl cycles starting
  // hs cycles after the first acceptance (cycle 1 = first RUN cycle).
  task automatic drive(input int n0, input int n1, input int l0, input int l1,
                       input int hs, input int hl);
    int   c0 = n0, c1 = n1, k = -1, guard = 0;
    logic a0, a1, fin = 1'b0;
    @(posedge Clk); #1;
    req0_len = LEN_W'(l0); req1_len = LEN_W'(l1);
    req0_valid = (c0 > 0); req1_valid = (c1 > 0);
    while (!fin && guard < 400) begin
      guard++;
      @(negedge Clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      if (!busy && !req0_valid && !req1_valid) fin = 1'b1;
      else begin
        @(posedge Clk); #1;
        if (a0) begin c0--; req0_valid = (c0 > 0); end
        if (a1) begin c1--; req1_valid = (c1 > 0); end
        if (a0 || a1) begin acc_t.push_back(cyc); if (k < 0) k = 0; end
        if (k >= 0) k++;
        if (hl != 0) Hold = (k >= hs) && (k < hs + hl);
      end
    end
    if (!fin) chk("drive_timeout", guard, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_En", En, 0);
    chk("rst_Slt", Slt, 0);
    chk("rst_done", {done, done_id}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    mon_on = 1'b1;

    // Tie straight after reset: port 0 first, then port 1.
    exp_cmd(1'b0, 2); exp_cmd(1'b1, 2);
    drive(1, 1, 2, 2, 0, 0);

    // Single burst of 3 on port 0.
    exp_cmd(1'b0, 3);
    drive(1, 0, 3, 0, 0, 0);

    // len 4 with two Hold cycles after the first increment.
    acc_q.push_back(1'b0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(4)});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, LEN_W'(3)});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, LEN_W'(3)});
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(3)});
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(2)});
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(1)});
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, '0});
    drive(1, 0, 4, 0, 2, 2);
    Hold = 1'b0;

    // Zero-length on port 1, with Hold high the whole time (no effect outside RUN).
    Hold = 1'b1;
    exp_cmd(1'b1, 0);
    drive(0, 1, 0, 0, 0, 0);
    Hold = 1'b0;

    // Continuous contention, len 1: alternating grants, 3-cycle period.
    acc_t.delete();
    exp_cmd(1'b0, 1); exp_cmd(1'b1, 1); exp_cmd(1'b0, 1); exp_cmd(1'b1, 1);
    drive(2, 2, 1, 1, 0, 0);
    chk("alt_accepts", acc_t.size(), 4);
    for (int i = 1; i < acc_t.size(); i++) chk("alt_period", acc_t[i] - acc_t[i-1], 3);

    // Reset while RUN shows remaining = 5.
    acc_q.push_back(1'b0);
    for (int i = 8; i >= 5; i--) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(i)});
    @(posedge Clk); #1;
    req0_len = LEN_W'(8); req0_valid = 1'b1;
    guard = 0;
    @(negedge Clk);
    while (!req0_ready && guard < 20) begin guard++; @(negedge Clk); end
    chk("rst_run_grant", req0_ready, 1);
    @(posedge Clk); #1 req0_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_run_En", En, 0);
    chk("rst_run_rem", remaining, 0);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_done", done, 0);

    // Reset restores port-0 priority on a tie.
    exp_cmd(1'b0, 1); exp_cmd(1'b1, 1);
    drive(1, 1, 1, 1, 0, 0);

    repeat (3) @(posedge Clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("acc_q_drained", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
